// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types, constants and pair schedule for the sort4_seq sorter
//
// Purpose : FSM state enum, default element width, and the fixed 5-step
//           compare-exchange schedule (index a, index b per step).
// Ports   : none (package).
// Options : SORT4_SWAPCNT_EN is consumed by sort4_seq_if.sv and sort4_seq.sv, not here.
package sort_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int NUM_STEPS     = 5;
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Optimal 4-input network: (0,1) (2,3) (0,2) (1,3) (1,2); a < b in every pair.
  localparam logic [1:0] STEP_A [NUM_STEPS] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd1};
  localparam logic [1:0] STEP_B [NUM_STEPS] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd2};

  // Out-of-range steps never occur in CMP; they map to a harmless pair.
  function automatic logic [1:0] pair_a(input logic [2:0] s);
    return (s <= LAST_STEP) ? STEP_A[s] : 2'd0;
  endfunction

  function automatic logic [1:0] pair_b(input logic [2:0] s);
    return (s <= LAST_STEP) ? STEP_B[s] : 2'd1;
  endfunction

endpackage

// File: rtl/sort4_seq_if.sv
// rtl/sort4_seq_if.sv - batch in / sorted result out handshake bundle for sort4_seq
//
// Purpose : groups the producer handshake (in_valid/in_ready, N1..N4), the
//           consumer handshake (out_valid/out_ready, S1..S4) and busy.
// Ports   : master = producer/consumer side, slave = sorter side.
// Options : SORT4_SWAPCNT_EN adds swap_cnt[2:0] (sorter -> consumer).
interface sort4_seq_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] N1, N2, N3, N4;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S1, S2, S3, S4;
  logic             busy;
`ifdef SORT4_SWAPCNT_EN
  logic [2:0]       swap_cnt;
`endif

`ifdef SORT4_SWAPCNT_EN
  modport master (
    output in_valid, N1, N2, N3, N4, out_ready,
    input  in_ready, out_valid, S1, S2, S3, S4, busy, swap_cnt
  );
  modport slave (
    input  in_valid, N1, N2, N3, N4, out_ready,
    output in_ready, out_valid, S1, S2, S3, S4, busy, swap_cnt
  );
`else
  modport master (
    output in_valid, N1, N2, N3, N4, out_ready,
    input  in_ready, out_valid, S1, S2, S3, S4, busy
  );
  modport slave (
    input  in_valid, N1, N2, N3, N4, out_ready,
    output in_ready, out_valid, S1, S2, S3, S4, busy
  );
`endif

endinterface

// File: rtl/sort4_seq_cmp_swap.sv
// rtl/sort4_seq_cmp_swap.sv - single unsigned compare-exchange cell
//
// Purpose : orders one pair; equal values pass straight through (no swap).
// Ports   : x, y (WIDTH, in)  - operand pair, x from the lower register index
//           lo, hi (WIDTH, out) - min / max of the pair
//           swapped (out)       - x > y, i.e. the pair was exchanged
module cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swapped
);

  assign swapped = (x > y);
  assign lo      = swapped ? y : x;
  assign hi      = swapped ? x : y;

endmodule

// File: rtl/sort4_seq.sv
// rtl/sort4_seq.sv - sequential 4-element unsigned sorter with one shared compare-exchange
//
// Purpose : loads a 4-word batch, runs the 5-step network through a single
//           cmp_swap over 5 cycles, then holds the ascending result.
// Ports   : clk         - rising-edge clock
//           rst_n       - asynchronous active-low reset
//           bus (slave) - in_valid/in_ready/N1..N4, out_valid/out_ready/S1..S4, busy
// Options : SORT4_SWAPCNT_EN adds bus.swap_cnt, the number of exchanging steps.
module sort4_seq
  import sort_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  sort4_seq_if.slave bus
);

  state_t           state;
  logic [2:0]       step;
  logic [WIDTH-1:0] r [4];
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [1:0]       pa;
  logic [1:0]       pb;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             swapped;

`ifdef SORT4_SWAPCNT_EN
  logic [2:0]       swap_cnt_q;
`endif

  // The one comparator is steered onto the pair selected by the current step.
  assign pa = pair_a(step);
  assign pb = pair_b(step);

  cmp_swap #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .x       (r[pa]),
    .y       (r[pb]),
    .lo      (lo),
    .hi      (hi),
    .swapped (swapped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      for (int i = 0; i < 4; i++) r[i] <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SORT4_SWAPCNT_EN
      swap_cnt_q  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone means accept.
          if (bus.in_valid) begin
            r[0]       <= bus.N1;
            r[1]       <= bus.N2;
            r[2]       <= bus.N3;
            r[3]       <= bus.N4;
            step       <= '0;
            state      <= CMP;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef SORT4_SWAPCNT_EN
            swap_cnt_q <= '0;
`endif
          end
        end

        CMP: begin
          r[pa] <= lo;
          r[pb] <= hi;
`ifdef SORT4_SWAPCNT_EN
          if (swapped) swap_cnt_q <= swap_cnt_q + 3'd1;
`endif
          if (step == LAST_STEP) begin
            step        <= '0;
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            step <= step + 3'd1;
          end
        end

        DONE: begin
          // No bypass to a new load: IDLE is always visited for one cycle.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          step        <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.S1        = r[0];
  assign bus.S2        = r[1];
  assign bus.S3        = r[2];
  assign bus.S4        = r[3];
`ifdef SORT4_SWAPCNT_EN
  assign bus.swap_cnt  = swap_cnt_q;
`endif

endmodule
